// File: rtl/au8_seq_pkg.sv
// Shared definitions for the AU8 operand-entry sequencer: state encoding and
// settle-counter width.
package au8_seq_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_WAIT_B = 3'd2,
        S_LOAD_B = 3'd3,
        S_SETTLE = 3'd4,
        S_LATCH  = 3'd5,
        S_DONE   = 3'd6,
        S_CLEAR  = 3'd7
    } seq_state_t;

    // Settle-counter preload: it counts down to zero, so SETTLE lasts n cycles.
    function automatic logic [CNT_W-1:0] settle_load(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/au8_sequencer_rise_detect.sv
// Rising-edge detector for a synchronous level; the delayed copy resets to
// RST_VAL so a level already high at reset release can be masked.
module rise_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) din_q <= RST_VAL;
        else        din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/au8_sequencer.sv
// Operand-entry sequencer for the 8-bit arithmetic unit: strobes A, B and the
// result register from user "enter" edges, with a settle gap before latching.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   IDLE     | waiting for the first enter edge
//   LOAD_A   | ld_a strobe
//   WAIT_B   | waiting for the B-entry edge (op sampled here)
//   LOAD_B   | ld_b strobe
//   SETTLE   | adder settling, SETTLE_CYC cycles
//   LATCH    | ld_r strobe, flags captured on exit
//   DONE     | result valid; next edge starts a new A entry
//   CLEAR    | au_clr pulse after abort, then IDLE
module au8_sequencer
    import au8_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       enter,
    input  logic       op,
    input  logic       abort,
    input  logic [3:0] ccout,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_r,
    output logic       au_clr,
    output logic       add_sub,
    output logic       busy,
    output logic       done,
    output logic [3:0] flags
);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             enter_rise;

    // enter_q resets high so a held key across reset release is not a command.
    rise_detect #(.RST_VAL(1'b1)) u_rise (
        .clk   (CLK),
        .rst_n (CLR),
        .din   (enter),
        .rise  (enter_rise)
    );

    // Outputs are assigned alongside the state they belong to, so they are
    // registered and valid for exactly the cycles spent in that state.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ld_a    <= 1'b0;
            ld_b    <= 1'b0;
            ld_r    <= 1'b0;
            au_clr  <= 1'b0;
            add_sub <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            flags   <= 4'h0;
        end else begin
            ld_a   <= 1'b0;
            ld_b   <= 1'b0;
            ld_r   <= 1'b0;
            au_clr <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            if (abort && state != S_CLEAR) begin
                state  <= S_CLEAR;
                au_clr <= 1'b1;
                busy   <= 1'b1;
                flags  <= 4'h0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (enter_rise) begin
                            state <= S_LOAD_A;
                            ld_a  <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                    S_LOAD_A: state <= S_WAIT_B;
                    S_WAIT_B: begin
                        if (enter_rise) begin
                            state   <= S_LOAD_B;
                            ld_b    <= 1'b1;
                            busy    <= 1'b1;
                            add_sub <= op;
                        end
                    end
                    S_LOAD_B: begin
                        busy <= 1'b1;
                        if (SETTLE_CYC == 0) begin
                            state <= S_LATCH;
                            ld_r  <= 1'b1;
                        end else begin
                            state <= S_SETTLE;
                            cnt   <= settle_load(SETTLE_CYC);
                        end
                    end
                    S_SETTLE: begin
                        busy <= 1'b1;
                        if (cnt == '0) begin
                            state <= S_LATCH;
                            ld_r  <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_LATCH: begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        flags <= ccout;
                    end
                    S_DONE: begin
                        if (enter_rise) begin
                            state <= S_LOAD_A;
                            ld_a  <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                    S_CLEAR: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_au8_sequencer.sv
// Self-checking bench for au8_sequencer: two instances (settle 2 and settle 0)
// share stimulus; per-scenario tasks check strobes, timing and flags.
module tb_au8_sequencer;

    logic       CLK;
    logic       CLR;
    logic       enter;
    logic       op;
    logic       abort;
    logic [3:0] ccout;

    logic ld_a0, ld_b0, ld_r0, au_clr0, add_sub0, busy0, done0;
    logic ld_a1, ld_b1, ld_r1, au_clr1, add_sub1, busy1, done1;
    logic [3:0] flags0, flags1;
    logic [10:0] o0, o1;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int         delay;
        logic [3:0] flags;
        logic       add_sub;
    } exp_t;
    exp_t sb[$];

    au8_sequencer #(.SETTLE_CYC(2)) dut0 (
        .CLK(CLK), .CLR(CLR), .enter(enter), .op(op), .abort(abort), .ccout(ccout),
        .ld_a(ld_a0), .ld_b(ld_b0), .ld_r(ld_r0), .au_clr(au_clr0), .add_sub(add_sub0),
        .busy(busy0), .done(done0), .flags(flags0)
    );

    au8_sequencer #(.SETTLE_CYC(0)) dut1 (
        .CLK(CLK), .CLR(CLR), .enter(enter), .op(op), .abort(abort), .ccout(ccout),
        .ld_a(ld_a1), .ld_b(ld_b1), .ld_r(ld_r1), .au_clr(au_clr1), .add_sub(add_sub1),
        .busy(busy1), .done(done1), .flags(flags1)
    );

    // {ld_a, ld_b, ld_r, au_clr, add_sub, busy, done, flags[3:0]}
    assign o0 = {ld_a0, ld_b0, ld_r0, au_clr0, add_sub0, busy0, done0, flags0};
    assign o1 = {ld_a1, ld_b1, ld_r1, au_clr1, add_sub1, busy1, done1, flags1};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        CLR = 1'b0; enter = 1'b0; op = 1'b0; abort = 1'b0; ccout = 4'h0;
        tick(); tick();
        total++;
        if (o0 !== 11'b0) begin bad++; $display("FAIL reset_s2 got=%b exp=%b", o0, 11'b0); end
        total++;
        if (o1 !== 11'b0) begin bad++; $display("FAIL reset_s0 got=%b exp=%b", o1, 11'b0); end
        CLR = 1'b1;
        tick();
        total++;
        if (o0 !== 11'b0) begin bad++; $display("FAIL reset_release got=%b exp=%b", o0, 11'b0); end
    endtask

    task automatic test_add();
        exp_t e;
        int   bclk;
        int   extra = 0;
        bit   seen = 0;
        e = '{0, 4'h0, 1'b0};
        op = 1'b0; ccout = 4'b0010; enter = 1'b1;
        tick();
        total++;
        if (o0 !== 11'b1_0_0_0_0_1_0_0000) begin bad++; $display("FAIL add_lda got=%b exp=%b", o0, 11'b1_0_0_0_0_1_0_0000); end
        enter = 1'b0;
        tick();
        total++;
        if (o0 !== 11'b0) begin bad++; $display("FAIL add_waitb got=%b exp=%b", o0, 11'b0); end
        enter = 1'b1; op = 1'b0;
        sb.push_back('{3, 4'b0010, 1'b0});
        tick();
        bclk = cyc;
        total++;
        if (o0 !== 11'b0_1_0_0_0_1_0_0000) begin bad++; $display("FAIL add_ldb got=%b exp=%b", o0, 11'b0_1_0_0_0_1_0_0000); end
        enter = 1'b0; op = 1'b1;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (ld_a0 || ld_b0) extra++;
            if (ld_r0) begin
                seen = 1;
                e = sb.pop_front();
                total++;
                if (cyc - bclk != e.delay) begin bad++; $display("FAIL add_ldr_delay got=%0d exp=%0d", cyc - bclk, e.delay); end
            end
        end
        if (!seen) begin total++; bad++; $display("FAIL add_ldr_timeout got=none exp=ld_r"); end
        total++;
        if (extra != 0) begin bad++; $display("FAIL add_extra_strobes got=%0d exp=0", extra); end
        tick();
        total++;
        if (o0 !== {5'b0000_0 | {4'b0000, e.add_sub}, 2'b01, e.flags}) begin
            bad++; $display("FAIL add_done got=%b exp=%b", o0, {4'b0000, e.add_sub, 2'b01, e.flags});
        end
        ccout = 4'b1111;
        tick();
        total++;
        if (flags0 !== 4'b0010 || done0 !== 1'b1) begin bad++; $display("FAIL add_flags_hold got=%b/%b exp=0010/1", flags0, done0); end
    endtask

    task automatic test_sub();
        exp_t e;
        int   bclk;
        bit   seen = 0;
        e = '{0, 4'h0, 1'b0};
        enter = 1'b1; tick();
        enter = 1'b0; tick();
        enter = 1'b1; op = 1'b1; ccout = 4'b1001;
        sb.push_back('{1, 4'b1001, 1'b1});
        tick();
        bclk = cyc;
        total++;
        if (add_sub1 !== 1'b1 || ld_b1 !== 1'b1) begin bad++; $display("FAIL sub_ldb got=%b%b exp=11", add_sub1, ld_b1); end
        enter = 1'b0; op = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (ld_r1) begin
                seen = 1;
                e = sb.pop_front();
                total++;
                if (cyc - bclk != e.delay) begin bad++; $display("FAIL sub_ldr_delay got=%0d exp=%0d", cyc - bclk, e.delay); end
            end
        end
        if (!seen) begin total++; bad++; $display("FAIL sub_ldr_timeout got=none exp=ld_r"); end
        tick();
        total++;
        if (done1 !== 1'b1 || flags1 !== e.flags || add_sub1 !== e.add_sub) begin
            bad++; $display("FAIL sub_done got=%b/%b/%b exp=1/%b/%b", done1, flags1, add_sub1, e.flags, e.add_sub);
        end
        repeat (6) tick();
    endtask

    task automatic test_abort_settle();
        int n = 0;
        ccout = 4'b1001;
        enter = 1'b1; tick();
        enter = 1'b0; tick();
        enter = 1'b1; op = 1'b0; tick();
        enter = 1'b0; tick();
        abort = 1'b1;
        tick();
        total++;
        if (o0 !== 11'b0_0_0_1_0_1_0_0000) begin bad++; $display("FAIL abort_clear got=%b exp=%b", o0, 11'b0_0_0_1_0_1_0_0000); end
        abort = 1'b0;
        tick();
        total++;
        if (o0 !== 11'b0) begin bad++; $display("FAIL abort_idle got=%b exp=%b", o0, 11'b0); end
        repeat (5) begin
            tick();
            if (ld_r0 || au_clr0) n++;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL abort_no_ldr got=%0d exp=0", n); end
    endtask

    task automatic test_abort_edge();
        int n = 0;
        enter = 1'b1; tick();
        enter = 1'b0; tick();
        enter = 1'b1; abort = 1'b1; op = 1'b1;
        tick();
        total++;
        if (o0 !== 11'b0_0_0_1_0_1_0_0000) begin bad++; $display("FAIL abort_edge_clear got=%b exp=%b", o0, 11'b0_0_0_1_0_1_0_0000); end
        abort = 1'b0; enter = 1'b0; op = 1'b0;
        repeat (6) begin
            tick();
            if (ld_b0) n++;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL abort_edge_ldb got=%0d exp=0", n); end
        total++;
        if (o0 !== 11'b0) begin bad++; $display("FAIL abort_edge_idle got=%b exp=%b", o0, 11'b0); end
    endtask

    task automatic test_ignore_settle();
        int bclk;
        int n = 0;
        ccout = 4'b0110;
        enter = 1'b1; tick();
        enter = 1'b0; tick();
        enter = 1'b1; op = 1'b0; tick();
        bclk = cyc;
        enter = 1'b0; tick();
        enter = 1'b1; tick();
        total++;
        if (o0 !== 11'b0_0_0_0_0_1_0_0000) begin bad++; $display("FAIL ign_settle got=%b exp=%b", o0, 11'b0_0_0_0_0_1_0_0000); end
        enter = 1'b0; tick();
        total++;
        if (ld_r0 !== 1'b1 || cyc - bclk != 3) begin bad++; $display("FAIL ign_ldr got=%b@%0d exp=1@3", ld_r0, cyc - bclk); end
        enter = 1'b1; tick();
        total++;
        if (o0 !== 11'b0_0_0_0_0_0_1_0110) begin bad++; $display("FAIL ign_done got=%b exp=%b", o0, 11'b0_0_0_0_0_0_1_0110); end
        repeat (4) begin
            tick();
            if (ld_a0 || !done0) n++;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL ign_held_enter got=%0d exp=0", n); end
    endtask

    task automatic test_reset_enter();
        int n = 0;
        enter = 1'b1; CLR = 1'b0;
        tick();
        total++;
        if (o0 !== 11'b0 || o1 !== 11'b0) begin bad++; $display("FAIL rst_enter_zero got=%b/%b exp=0", o0, o1); end
        CLR = 1'b1;
        repeat (10) begin
            tick();
            if (ld_a0 || ld_a1) n++;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL rst_enter_no_lda got=%0d exp=0", n); end
        enter = 1'b0; tick();
        enter = 1'b1; tick();
        total++;
        if (ld_a0 !== 1'b1 || ld_a1 !== 1'b1) begin bad++; $display("FAIL rst_enter_lda got=%b%b exp=11", ld_a0, ld_a1); end
    endtask

    task automatic test_reset_latch();
        int  n = 0;
        bit  seen = 0;
        enter = 1'b0; tick();
        enter = 1'b1; op = 1'b1; ccout = 4'b1100; tick();
        enter = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (ld_r0) seen = 1;
        end
        if (!seen) begin total++; bad++; $display("FAIL rst_latch_timeout got=none exp=ld_r"); end
        CLR = 1'b0;
        #1;
        total++;
        if (o0 !== 11'b0 || o1 !== 11'b0) begin bad++; $display("FAIL rst_latch_async got=%b/%b exp=0", o0, o1); end
        tick();
        CLR = 1'b1;
        repeat (4) begin
            tick();
            if (ld_a0 || ld_b0 || ld_r0 || au_clr0) n++;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL rst_latch_strobes got=%0d exp=0", n); end
        total++;
        if (o0 !== 11'b0) begin bad++; $display("FAIL rst_latch_idle got=%b exp=%b", o0, 11'b0); end
        enter = 1'b1; tick();
        total++;
        if (ld_a0 !== 1'b1) begin bad++; $display("FAIL rst_latch_restart got=%b exp=1", ld_a0); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_abort_settle();
        test_abort_edge();
        test_ignore_settle();
        test_reset_enter();
        test_reset_latch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/au8_sequencer.md
AU8_SEQUENCER -- requirements
Module: au8_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2, adder settle cycles between B load and result latch (legal 0..15).
REQ-002 SHALL have port CLK  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port CLR  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port enter  in  1  synchronous user "enter" level; rising edge is the command.
REQ-005 SHALL have port op  in  1  0 = add, 1 = subtract; sampled on the B-entry edge.
REQ-006 SHALL have port abort  in  1  synchronous level; any cycle returns sequence to idle.
REQ-007 SHALL have port ccout  in  4  AU flags {Cout, Ovr, Zero, Neg} from the arithmetic unit.
REQ-008 SHALL have port ld_a  out  1  one-cycle load strobe to register A.
REQ-009 SHALL have port ld_b  out  1  one-cycle load strobe to register B.
REQ-010 SHALL have port ld_r  out  1  one-cycle load strobe to result register.
REQ-011 SHALL have port au_clr  out  1  one-cycle clear pulse to AU registers, active-high.
REQ-012 SHALL have port add_sub  out  1  registered operation select to AU.
REQ-013 SHALL have port busy  out  1  high while strobing, settling or clearing.
REQ-014 SHALL have port done  out  1  high in DONE state.
REQ-015 SHALL have port flags  out  4  ccout captured at result latch.

Function
REQ-016 SHALL detect edge = enter & ~enter_q, enter_q being enter delayed one cycle.
REQ-017 SHALL implement states IDLE, LOAD_A, WAIT_B, LOAD_B, SETTLE, LATCH, DONE, CLEAR; all outputs Moore-registered.
REQ-018 SHALL transition IDLE -edge-> LOAD_A -> WAIT_B -edge-> LOAD_B -> SETTLE -> LATCH -> DONE -edge-> LOAD_A.
REQ-019 SHALL assert ld_a only in LOAD_A, ld_b only in LOAD_B, ld_r only in LATCH, au_clr only in CLEAR, each exactly one cycle.
REQ-020 SHALL latch add_sub <= op on the WAIT_B edge; add_sub holds until next such edge or reset.
REQ-021 SHALL remain in SETTLE exactly SETTLE_CYC cycles via 4-bit down-counter; SETTLE_CYC = 0 goes LOAD_B -> LATCH directly.
REQ-022 SHALL, for edge sampled at clock k in WAIT_B, assert ld_b in cycle k+1, ld_r in cycle k+2+SETTLE_CYC, done from cycle k+3+SETTLE_CYC.
REQ-023 SHALL capture flags <= ccout on the clock ending LATCH; flags hold until next LATCH, CLEAR, or reset.
REQ-024 SHALL ignore (not queue) edges in LOAD_A, LOAD_B, SETTLE, LATCH, CLEAR.
REQ-025 SHALL, on abort in any state except CLEAR, enter CLEAR next cycle, then IDLE; CLEAR zeroes flags.
REQ-026 SHALL give abort priority over a simultaneous edge.
REQ-027 SHALL drive busy = 1 in LOAD_A, LOAD_B, SETTLE, LATCH, CLEAR; 0 elsewhere.
REQ-028 SHALL hold enter high continuously as a single command (no auto-repeat).

Reset
REQ-029 SHALL, while CLR = 0, force state IDLE, counter 0, ld_a/ld_b/ld_r/au_clr/add_sub/busy/done = 0, flags = 4'h0.
REQ-030 SHALL reset enter_q to 1 so enter held high across reset release produces no command.
REQ-031 SHALL abandon any in-flight sequence on reset with no further strobes.

Structure
REQ-032 SHALL place state enumeration, encodings and counter width in shared package au8_seq_pkg.
REQ-033 SHALL implement edge detection in one sub-module, rise_detect (reset value parameterised).

Verification
REQ-034 SHALL test add: SETTLE_CYC=2, edge, edge with op=0, ccout=4'b0010 -> ld_a, ld_b, ld_r one cycle each; ld_r 4 cycles after B edge; flags=4'b0010; done=1.
REQ-035 SHALL test subtract with SETTLE_CYC=0: op=1 on B edge -> add_sub=1; ld_r 2 cycles after B edge.
REQ-036 SHALL test abort in SETTLE -> au_clr one cycle next cycle, no ld_r, flags=0, IDLE after CLEAR.
REQ-037 SHALL test abort and edge same cycle in WAIT_B -> CLEAR taken, ld_b never asserted.
REQ-038 SHALL test enter high during reset release, held 10 cycles -> no ld_a; edges during SETTLE -> ignored.
REQ-039 SHALL test CLR low mid-LATCH -> all outputs 0 immediately, IDLE after release.
